// File: rtl/mac_seq_pkg.sv
// Shared definitions for the posit MAC sequencer: state encoding and the
// geometry of the stage-valid vector driven into the datapath.
package mac_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FEED  = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_DONE  = 3'd3;
  localparam state_t S_CLEAR = 3'd4;

  localparam int PIPE_DEF = 12;
  // Position of the job-active flag inside the stage-valid vector.
  localparam int JOB_BIT  = PIPE_DEF - 1;

  // States in which a job owns the accumulators.
  function automatic logic is_job_state(input state_t s);
    return (s == S_FEED) || (s == S_DRAIN) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/vld_delay_line.sv
// Beat-valid delay line feeding per-stage enables; a synchronous clear flushes
// all in-flight strobes in one cycle.
module vld_delay_line #(
  parameter int DEPTH = 11
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             clr,
  input  logic             d,
  output logic [DEPTH-1:0] q
);

  // Stage 0 is the registered input strobe; stage i follows stage i-1.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= {q[DEPTH-2:0], d};
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// K-term dot-product sequencer for the posit MAC pipeline.
// Optional drain watchdog enabled by defining MAC_SEQ_WDOG_EN.
module mac_seq_ctrl
  import mac_seq_pkg::*;
#(
  parameter int K        = 9,
  parameter int PIPE     = PIPE_DEF,
  parameter int WK       = $clog2(K) + 1,
  parameter int WDOG_CYC = 32
) (
  input  logic            clk_i,
  input  logic            rstn,
  input  logic            start_i,
  input  logic            in_vld_i,
  output logic            in_rdy_o,
  output logic [PIPE-1:0] vld_d_o,
  input  logic            acc_rdy_i,
  output logic            out_vld_o,
  input  logic            out_rdy_i,
  output logic            busy_o,
  output logic [WK-1:0]   term_cnt_o,
  output logic            err_o
);

  localparam logic [WK-1:0] K_W    = WK'(K);
  localparam logic [WK-1:0] K_LAST = WK'(K - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WK-1:0]   term_cnt;
  logic            job_act;
  logic            accept;
  logic            start_acc;
  logic            wdog_fire;
  logic [PIPE-2:0] dl_q;

  assign in_rdy_o   = (state == S_FEED) && (term_cnt < K_W);
  assign accept     = in_vld_i && in_rdy_o;
  assign start_acc  = (state == S_IDLE) && start_i;
  assign term_cnt_o = term_cnt;
  assign vld_d_o    = {job_act, dl_q};

`ifdef MAC_SEQ_WDOG_EN
  localparam int            WW        = $clog2(WDOG_CYC) + 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

  logic [WW-1:0] wdog_cnt;

  assign wdog_fire = (state == S_DRAIN) && !acc_rdy_i && (wdog_cnt == WDOG_LAST);

  // Counts cycles spent in DRAIN; restarts from zero on every entry.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      wdog_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      wdog_cnt <= (state == S_DRAIN) ? wdog_cnt + 1'b1 : '0;
      if (start_acc)      err_o <= 1'b0;
      else if (wdog_fire) err_o <= 1'b1;
    end
  end
`else
  logic unused_wdog_cfg;

  assign wdog_fire       = 1'b0;
  assign err_o           = 1'b0;
  assign unused_wdog_cfg = (WDOG_CYC > 0);
`endif

  always_comb begin
    // NOTE: default assignment before the case so every path assigns state_nxt; no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = S_FEED;
      S_FEED:  if (accept && (term_cnt == K_LAST)) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (acc_rdy_i)      state_nxt = S_DONE;
        else if (wdog_fire) state_nxt = S_CLEAR;
      end
      S_DONE:  if (out_rdy_i) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Flags are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      term_cnt  <= '0;
      job_act   <= 1'b0;
      busy_o    <= 1'b0;
      out_vld_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
      state     <= state_nxt;
      job_act   <= is_job_state(state_nxt);
      busy_o    <= (state_nxt != S_IDLE);
      out_vld_o <= (state_nxt == S_DONE);
      if (start_acc)   term_cnt <= '0;
      else if (accept) term_cnt <= term_cnt + 1'b1;
    end
  end

  // Entering CLEAR flushes in-flight strobes so the CLEAR cycle is all-zero.
  vld_delay_line #(
    .DEPTH (PIPE - 1)
  ) u_vld_delay_line (
    .clk_i (clk_i),
    .rstn  (rstn),
    .clr   (state_nxt == S_CLEAR),
    .d     (accept),
    .q     (dl_q)
  );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed jobs with randomized gaps,
// drain latency and backpressure, checked against an event-time reference.
module tb_mac_seq_ctrl;

  localparam int K    = 9;
  localparam int PIPE = 12;
  localparam int WK   = $clog2(K) + 1;
  localparam int WDOG = 32;

  logic            clk_i;
  logic            rstn;
  logic            start_i;
  logic            in_vld_i;
  logic            in_rdy_o;
  logic [PIPE-1:0] vld_d_o;
  logic            acc_rdy_i;
  logic            out_vld_o;
  logic            out_rdy_i;
  logic            busy_o;
  logic [WK-1:0]   term_cnt_o;
  logic            err_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_q[$];
  int gaps[K];

  mac_seq_ctrl #(
    .K        (K),
    .PIPE     (PIPE),
    .WDOG_CYC (WDOG)
  ) dut (
    .clk_i      (clk_i),
    .rstn       (rstn),
    .start_i    (start_i),
    .in_vld_i   (in_vld_i),
    .in_rdy_o   (in_rdy_o),
    .vld_d_o    (vld_d_o),
    .acc_rdy_i  (acc_rdy_i),
    .out_vld_o  (out_vld_o),
    .out_rdy_i  (out_rdy_i),
    .busy_o     (busy_o),
    .term_cnt_o (term_cnt_o),
    .err_o      (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. acc: bench expects a beat accepted in the ending cycle.
  // clr: the ending cycle is expected to enter the all-zero clear cycle.
  // The delay-line bits are predicted from the recorded accept times.
  task automatic tick(input bit acc, input bit clr);
    logic [PIPE-2:0] exp_dl;
    @(posedge clk_i);
    if (acc) acc_q.push_back(cyc);
    cyc++;
    if (clr) acc_q.delete();
    #1;
    exp_dl = '0;
    foreach (acc_q[j]) begin
      int age;
      age = cyc - 1 - acc_q[j];
      if (age >= 0 && age <= PIPE - 2) exp_dl[age] = 1'b1;
    end
    check("delay_line", 32'(vld_d_o[PIPE-2:0]), 32'(exp_dl));
  endtask

  task automatic start_and_feed(input int gap [K], input bit spur);
    check("idle_rdy", 32'(in_rdy_o), 0);
    check("idle_busy", 32'(busy_o), 0);
    start_i = 1'b1;
    tick(0, 0);
    start_i = 1'b0;
    check("start_busy", 32'(busy_o), 1);
    check("start_job_bit", 32'(vld_d_o[PIPE-1]), 1);
    check("start_cnt", 32'(term_cnt_o), 0);
    check("start_err", 32'(err_o), 0);
    for (int b = 0; b < K; b++) begin
      for (int g = 0; g < gap[b]; g++) begin
        in_vld_i  = 1'b0;
        acc_rdy_i = spur && (g == 0);
        check("gap_rdy", 32'(in_rdy_o), 1);
        check("gap_nonzero", 32'(vld_d_o != '0), 1);
        tick(0, 0);
      end
      acc_rdy_i = 1'b0;
      in_vld_i  = 1'b1;
      check("feed_rdy", 32'(in_rdy_o), 1);
      check("feed_job_bit", 32'(vld_d_o[PIPE-1]), 1);
      check("feed_no_out", 32'(out_vld_o), 0);
      tick(1, 0);
      check("term_cnt", 32'(term_cnt_o), 32'(b + 1));
    end
    in_vld_i = 1'b0;
  endtask

  task automatic finish_job(input int drain_lat, input int bp);
    for (int d = 0; d < drain_lat; d++) begin
      in_vld_i = 1'($urandom_range(0, 1));
      start_i  = 1'($urandom_range(0, 1));
      check("drain_rdy", 32'(in_rdy_o), 0);
      check("drain_out", 32'(out_vld_o), 0);
      check("drain_job_bit", 32'(vld_d_o[PIPE-1]), 1);
      tick(0, 0);
    end
    in_vld_i  = 1'b0;
    start_i   = 1'b0;
    acc_rdy_i = 1'b1;
    check("drain_rdy_last", 32'(in_rdy_o), 0);
    check("drain_out_last", 32'(out_vld_o), 0);
    tick(0, 0);
    acc_rdy_i = 1'b0;
    for (int i = 0; i < bp; i++) begin
      out_rdy_i = 1'b0;
      start_i   = 1'($urandom_range(0, 1));
      in_vld_i  = 1'($urandom_range(0, 1));
      check("done_out_vld", 32'(out_vld_o), 1);
      check("done_rdy", 32'(in_rdy_o), 0);
      check("done_busy", 32'(busy_o), 1);
      check("done_cnt", 32'(term_cnt_o), K);
      tick(0, 0);
    end
    start_i   = 1'b0;
    in_vld_i  = 1'b0;
    out_rdy_i = 1'b1;
    check("hs_out_vld", 32'(out_vld_o), 1);
    check("hs_job_bit", 32'(vld_d_o[PIPE-1]), 1);
    tick(0, 1);
    out_rdy_i = 1'b0;
    check("clear_vld_zero", 32'(vld_d_o), 0);
    check("clear_out", 32'(out_vld_o), 0);
    check("clear_busy", 32'(busy_o), 1);
    tick(0, 0);
    check("idle_after_busy", 32'(busy_o), 0);
    check("idle_after_vld", 32'(vld_d_o), 0);
    check("idle_after_rdy", 32'(in_rdy_o), 0);
  endtask

  initial begin
    rstn      = 1'b0;
    start_i   = 1'b0;
    in_vld_i  = 1'b0;
    acc_rdy_i = 1'b0;
    out_rdy_i = 1'b0;
    #3;
    check("rst_vld", 32'(vld_d_o), 0);
    check("rst_rdy", 32'(in_rdy_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_out", 32'(out_vld_o), 0);
    check("rst_cnt", 32'(term_cnt_o), 0);
    check("rst_err", 32'(err_o), 0);
    tick(0, 0);
    tick(0, 0);
    rstn = 1'b1;
    tick(0, 0);

    // Nominal: back-to-back beats, acc_rdy 6 cycles after last accept, immediate out_rdy.
    foreach (gaps[i]) gaps[i] = 0;
    start_and_feed(gaps, 1'b0);
    finish_job(5, 0);

    // Bubbles: 20 idle cycles between beats 4 and 5.
    gaps[4] = 20;
    start_and_feed(gaps, 1'b0);
    finish_job(3, 0);

    // Backpressure: 15 cycles with out_rdy low, start pulses ignored.
    foreach (gaps[i]) gaps[i] = 0;
    start_and_feed(gaps, 1'b0);
    finish_job(2, 15);

    // Randomized jobs with spurious acc_rdy during FEED.
    for (int j = 0; j < 4; j++) begin
      foreach (gaps[i]) gaps[i] = $urandom_range(0, 3);
      gaps[0] = 1;
      start_and_feed(gaps, 1'b1);
      finish_job($urandom_range(0, 8), $urandom_range(0, 4));
    end

    // Reset mid-FEED after 5 accepts.
    check("pre_rst_idle", 32'(busy_o), 0);
    start_i = 1'b1;
    tick(0, 0);
    start_i  = 1'b0;
    in_vld_i = 1'b1;
    for (int b = 0; b < 5; b++) tick(1, 0);
    check("mid_cnt", 32'(term_cnt_o), 5);
    rstn = 1'b0;
    #1;
    acc_q.delete();
    check("mid_rst_vld", 32'(vld_d_o), 0);
    check("mid_rst_rdy", 32'(in_rdy_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_cnt", 32'(term_cnt_o), 0);
    check("mid_rst_out", 32'(out_vld_o), 0);
    in_vld_i = 1'b0;
    tick(0, 0);
    tick(0, 0);
    rstn = 1'b1;
    tick(0, 0);
    foreach (gaps[i]) gaps[i] = 0;
    start_and_feed(gaps, 1'b0);
    finish_job(1, 1);

    // Drain with acc_rdy never asserted.
    start_and_feed(gaps, 1'b0);
`ifdef MAC_SEQ_WDOG_EN
    for (int d = 1; d <= WDOG; d++) begin
      check("wdog_wait_out", 32'(out_vld_o), 0);
      check("wdog_wait_err", 32'(err_o), 0);
      tick(0, d == WDOG);
    end
    check("wdog_err", 32'(err_o), 1);
    check("wdog_clear", 32'(vld_d_o), 0);
    check("wdog_no_out", 32'(out_vld_o), 0);
    tick(0, 0);
    check("wdog_idle", 32'(busy_o), 0);
    check("wdog_sticky", 32'(err_o), 1);
    start_and_feed(gaps, 1'b0);
    finish_job(0, 0);
`else
    for (int d = 0; d < 100; d++) begin
      check("drain_hold_out", 32'(out_vld_o), 0);
      check("drain_hold_busy", 32'(busy_o), 1);
      check("drain_hold_err", 32'(err_o), 0);
      tick(0, 0);
    end
    finish_job(0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
